// File: rtl/buzzer_player.sv
// Valid/ready note consumer: plays each accepted note code as a square wave on the buzzer
// pin for (len+1) beats. Define BUZZER_PLAYER_GAP_EN to add a silent gap after every note.
module buzzer_player #(
   parameter int CLK_HZ      = 100_000_000,
   parameter int BEAT_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 2_500_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] note_code,
   input  logic [1:0] note_len,
   input  logic       note_valid,
   output logic       note_ready,
   input  logic       stop,
   output logic       buzzer,
   output logic       busy,
   output logic [3:0] cur_note
);

   function automatic int hp(input int f);
      int h;
      h = CLK_HZ / (2 * f);
      return (h < 1) ? 1 : h;
   endfunction

   // 262 Hz is the lowest tone, so it sets the half-period counter width
   localparam int H_MAX   = hp(262);
   localparam int HW      = (H_MAX > 1) ? $clog2(H_MAX) : 1;
   localparam int DUR_MAX = 4 * BEAT_CYCLES;
   localparam int DW      = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
   localparam int GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [1:0] {IDLE = 2'd0, TONE = 2'd1, GAP = 2'd2} state_t;

`ifdef BUZZER_PLAYER_GAP_EN
   localparam state_t TONE_EXIT = (GAP_CYCLES > 0) ? GAP : IDLE;
`else
   localparam state_t TONE_EXIT = IDLE;
`endif

   function automatic logic [HW-1:0] half_last(input logic [3:0] c);
      int h;
      case (c)
         4'd1:    h = hp(262);
         4'd2:    h = hp(294);
         4'd3:    h = hp(330);
         4'd4:    h = hp(349);
         4'd5:    h = hp(392);
         4'd6:    h = hp(440);
         4'd7:    h = hp(494);
         4'd8:    h = hp(523);
         4'd9:    h = hp(587);
         4'd10:   h = hp(659);
         4'd11:   h = hp(698);
         4'd12:   h = hp(784);
         4'd13:   h = hp(880);
         4'd14:   h = hp(988);
         default: h = 1;
      endcase
      return HW'(h - 1);
   endfunction

   state_t          r_state;
   state_t          w_next;
   logic            r_buzzer;
   logic [3:0]      r_cur_note;
   logic            r_rest;
   logic [HW-1:0]   r_half_cnt;
   logic [HW-1:0]   r_half_last;
   logic [DW-1:0]   r_dur_cnt;
   logic [DW-1:0]   r_dur_last;
   logic [GW-1:0]   r_gap_cnt;

   logic            w_accept;
   logic            w_half_wrap;
   logic            w_dur_done;
   logic            w_gap_done;
   logic            w_rest_in;
   logic [HW-1:0]   w_half_last_in;
   logic [DW-1:0]   w_dur_last_in;

   assign note_ready = (r_state == IDLE);
   assign busy       = ~note_ready;
   assign buzzer     = r_buzzer;
   assign cur_note   = r_cur_note;

   // stop in IDLE blocks the handshake on that edge
   assign w_accept       = (r_state == IDLE) && note_valid && !stop;
   assign w_half_wrap    = (r_half_cnt == r_half_last);
   assign w_dur_done     = (r_dur_cnt == r_dur_last);
   assign w_gap_done     = (r_gap_cnt == GW'(GAP_LAST));
   assign w_rest_in      = (note_code == 4'd0) || (note_code == 4'd15);
   assign w_half_last_in = half_last(note_code);
   assign w_dur_last_in  = DW'((int'(note_len) + 1) * BEAT_CYCLES - 1);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_next = TONE;
         TONE: begin
            if (stop)            w_next = IDLE;
            else if (w_dur_done) w_next = TONE_EXIT;
         end
         GAP:  if (stop || w_gap_done) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_buzzer    <= 1'b0;
         r_cur_note  <= 4'd0;
         r_rest      <= 1'b0;
         r_half_cnt  <= '0;
         r_half_last <= '0;
         r_dur_cnt   <= '0;
         r_dur_last  <= '0;
         r_gap_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_buzzer <= 1'b0;
               if (w_accept) begin
                  r_cur_note  <= note_code;
                  r_rest      <= w_rest_in;
                  r_half_last <= w_half_last_in;
                  r_dur_last  <= w_dur_last_in;
                  r_half_cnt  <= '0;
                  r_dur_cnt   <= '0;
               end
            end
            TONE: begin
               if (stop || w_dur_done) begin
                  r_buzzer   <= 1'b0;
                  r_cur_note <= 4'd0;
                  r_gap_cnt  <= '0;
               end else begin
                  r_dur_cnt <= r_dur_cnt + DW'(1);
                  if (w_half_wrap) begin
                     r_half_cnt <= '0;
                     r_buzzer   <= r_rest ? 1'b0 : ~r_buzzer;
                  end else begin
                     r_half_cnt <= r_half_cnt + HW'(1);
                  end
               end
            end
            GAP: begin
               r_buzzer   <= 1'b0;
               r_cur_note <= 4'd0;
               r_gap_cnt  <= w_gap_done ? '0 : r_gap_cnt + GW'(1);
            end
            default: begin
               r_buzzer   <= 1'b0;
               r_cur_note <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_buzzer_player.sv
// Scoreboard bench for buzzer_player: the driver queues per-note expectations, the monitor
// measures each accepted note (first rise, edge count, tone cycles, ready latency).
module tb_buzzer_player;
   localparam int CLK_HZ = 8800;
   localparam int BEAT   = 100;
   localparam int GAPC   = 10;
`ifdef BUZZER_PLAYER_GAP_EN
   localparam int G = GAPC;
`else
   localparam int G = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] note_code = 4'd0;
   logic [1:0] note_len = 2'd0;
   logic       note_valid = 1'b0;
   logic       stop = 1'b0;
   logic       note_ready, buzzer, busy;
   logic [3:0] cur_note;

   buzzer_player #(.CLK_HZ(CLK_HZ), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC)) dut (
      .clk(clk), .rst_n(rst_n), .note_code(note_code), .note_len(note_len),
      .note_valid(note_valid), .note_ready(note_ready), .stop(stop),
      .buzzer(buzzer), .busy(busy), .cur_note(cur_note)
   );

   always #5 clk = ~clk;

   typedef struct {
      int code;
      int first_rise;
      int trans;
      int ready_lat;
      int tone_cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   note_idx = 0;
   bit   mon_busy = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // monitor: every handshake edge pops one expectation and measures the note
   initial begin
      forever begin
         @(posedge clk);
         if (rst_n && note_valid && note_ready && !stop) begin
            exp_t e;
            int   fr, tr, tc, rl;
            logic pb;
            mon_busy = 1'b1;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_accept actual=code%0d required=no_accept", note_code);
               e.code = -1; e.first_rise = -2; e.trans = -2; e.ready_lat = -2; e.tone_cnt = -2;
            end else begin
               e = sb.pop_front();
            end
            fr = -1; tr = 0; tc = 0; rl = -1; pb = buzzer;
            for (int n = 0; n < 2000; n++) begin
               @(negedge clk);
               if (buzzer !== pb) tr++;
               pb = buzzer;
               if (buzzer === 1'b1 && fr < 0) fr = n;
               if (busy === 1'b1 && int'(cur_note) == e.code) tc++;
               if (note_ready === 1'b1) begin
                  rl = n;
                  break;
               end
               @(posedge clk);
            end
            chk($sformatf("n%0d_first_rise", note_idx), fr, e.first_rise);
            chk($sformatf("n%0d_transitions", note_idx), tr, e.trans);
            chk($sformatf("n%0d_tone_cycles", note_idx), tc, e.tone_cnt);
            chk($sformatf("n%0d_ready_latency", note_idx), rl, e.ready_lat);
            chk($sformatf("n%0d_end_buzzer", note_idx), int'(buzzer), 0);
            chk($sformatf("n%0d_end_cur_note", note_idx), int'(cur_note), 0);
            note_idx++;
            mon_busy = 1'b0;
         end
      end
   end

   // called and returns at a negedge; returns in the first cycle after the accept edge
   task automatic send(input int code, input int len, input exp_t e, input bit keep);
      int i;
      sb.push_back(e);
      note_code  = 4'(code);
      note_len   = 2'(len);
      note_valid = 1'b1;
      for (i = 0; i < 3000 && !note_ready; i++) @(negedge clk);
      if (!note_ready) chk("send_ready_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      if (!keep) note_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 3000 && !note_ready; i++) @(negedge clk);
      if (!note_ready) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_buzzer", int'(buzzer), 0);
      chk("rst_cur_note", int'(cur_note), 0);
      chk("rst_note_ready", int'(note_ready), 1);
      chk("rst_busy", int'(busy), 0);

      // A4, one beat, H=10
      send(6, 0, '{6, 10, 10, 100 + G, 100}, 1'b0);
      wait_idle();
      // C5, two beats, H=8
      send(8, 1, '{8, 8, 24, 200 + G, 200}, 1'b0);
      wait_idle();
      // four-beat rest: cur_note is 0 throughout, gap included
      send(0, 3, '{0, -1, 0, 400 + G, 400 + G}, 1'b0);
      wait_idle();

      // stop sampled at the end of TONE cycle 37, then a new note on the next edge
      send(6, 0, '{6, 10, 4, 37, 37}, 1'b0);
      repeat (36) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      send(1, 0, '{1, 16, 6, 100 + G, 100}, 1'b0);
      wait_idle();

      // reset during TONE cycle 50, valid held high while in reset
      send(8, 0, '{8, 8, 6, 50, 50}, 1'b0);
      repeat (49) @(negedge clk);
      rst_n      = 1'b0;
      note_code  = 4'd5;
      note_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rstv%0d_busy", i), int'(busy), 0);
         chk($sformatf("rstv%0d_cur_note", i), int'(cur_note), 0);
         chk($sformatf("rstv%0d_buzzer", i), int'(buzzer), 0);
      end
      note_valid = 1'b0;
      rst_n      = 1'b1;
      @(negedge clk);

      // back-to-back stream with valid held high
      send(1, 0, '{1, 16, 6, 100 + G, 100}, 1'b1);
      send(2, 0, '{2, 14, 8, 100 + G, 100}, 1'b1);
      send(3, 0, '{3, 13, 8, 100 + G, 100}, 1'b0);
      wait_idle();

      for (int i = 0; i < 50 && mon_busy; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      chk("notes_seen", note_idx, 9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/buzzer_player.md
# buzzer_player

Consumer end of the song library's note stream. Accepts one 4-bit note code at a time over a valid/ready handshake, plays it on the buzzer pin as a square wave for a programmable number of beats, then inserts an optional articulation gap before accepting the next note. It sits between the song library/sequencer and the board buzzer pin and is the only block that drives that pin.

## Interface
Parameters:
- CLK_HZ, 100_000_000, clock frequency in Hz; used to derive the tone half-periods.
- BEAT_CYCLES, 25_000_000, clock cycles per beat.
- GAP_CYCLES, 2_500_000, clock cycles of silence after each note (used only when the gap is compiled in).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- note_code  in  4  note to play: 0 = rest, 1–7 = C4..B4, 8–14 = C5..B5, 15 = rest.
- note_len  in  2  duration is (note_len+1) beats.
- note_valid  in  1  note_code and note_len are valid.
- note_ready  out  1  high only in IDLE; a transfer occurs on an edge where valid and ready are both 1.
- stop  in  1  synchronous abort.
- buzzer  out  1  square-wave output to the buzzer pin.
- busy  out  1  equals ~note_ready.
- cur_note  out  4  code being played; 0 in IDLE and GAP.

## Operation
- States are IDLE, TONE and GAP. All outputs are registered or decoded from the state register.
- **Reset** (rst_n=0 at an edge): state goes to IDLE, buzzer=0, cur_note=0, and all counters clear. note_ready=1 and busy=0 from the first cycle after reset. Reset overrides stop and accept, and applies in every state.
- **IDLE → TONE** on accept:
  - Latch the code and duration, and set cur_note=note_code.
  - Clear half_cnt and dur_cnt, and set buzzer=0.
- **Tone generation in TONE**:
  - Half-period H[n] = CLK_HZ/(2·f[n]), truncated, computed at elaboration and clamped to a minimum of 1.
  - Frequencies in Hz: 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988.
  - Each cycle: if half_cnt==H−1 then half_cnt←0 and buzzer←~buzzer; otherwise half_cnt increments.
  - Rest codes (0, 15) hold buzzer=0 for the full duration.
- **Duration**: dur_cnt counts TONE cycles. At dur_cnt==(len+1)·BEAT_CYCLES−1:
  - buzzer←0 and cur_note←0;
  - next state is GAP, or IDLE when the gap is compiled out.
- **GAP**: buzzer=0 for GAP_CYCLES cycles, then IDLE.
- **stop**: in TONE or GAP, the next state is IDLE with buzzer=0 and cur_note=0. In IDLE, stop has no effect, and stop=1 blocks any accept on that edge.
- Inputs are ignored when not ready; the upstream block must hold valid and data until the transfer.
- Counter widths: sized with $clog2 of the largest terminal count, (4·BEAT_CYCLES) and the largest H. No wrap-around is permitted within a note.

## Timing
- Accept on edge k gives TONE in cycles k+1 .. k+(len+1)·BEAT_CYCLES.
- The first buzzer rise occurs H cycles after entering TONE.
- GAP occupies the following GAP_CYCLES cycles.
- note_ready is high again (len+1)·BEAT_CYCLES + GAP_CYCLES cycles after the accepting edge.
- The minimum note-to-note spacing equals that figure; there is no back-to-back accept in the final TONE or GAP cycle.
- stop asserted at edge j gives buzzer=0 and note_ready=1 in cycle j+1. A new note can be accepted at edge j+1.

## Configuration
- Macro BUZZER_PLAYER_GAP_EN, compiled-in feature: the articulation gap.
  - Defined: the GAP state exists, with GAP_CYCLES of silence after every note.
  - Undefined: TONE goes directly to IDLE, and note_ready returns (len+1)·BEAT_CYCLES cycles after accept. GAP_CYCLES is ignored.

## Test plan
Parameters for all scenarios: CLK_HZ=8800, BEAT_CYCLES=100, GAP_CYCLES=10.
- **Reset**: rst_n=0 for 3 cycles, then release → buzzer=0, cur_note=0, note_ready=1, busy=0.
- **Single A4 note**: code 6, len 0 (H=10) → buzzer toggles every 10 cycles, rising at cycle 10 after accept, 10 toggles in the 100 TONE cycles. cur_note=6 during TONE. note_ready returns 110 cycles after accept (100 with the gap compiled out).
- **Long note and rest**: code 8, len 1 (H=8) plays for 200 cycles. Then code 0, len 3 → buzzer stays 0 for 400 cycles and note_ready returns 410 cycles after the rest's accept.
- **stop mid-tone**: assert at TONE cycle 37 → next cycle buzzer=0, cur_note=0, note_ready=1. A new note (code 1) is accepted on the following edge.
- **Reset mid-note**: rst_n=0 in TONE cycle 50 → IDLE next cycle with all outputs at reset values. No accept while rst_n=0, even with note_valid=1.
- **Back-to-back stream**: valid held high with codes 1,2,3 → exactly one accept per note_ready window. cur_note sequence is 1,2,3, and no code is dropped or duplicated.
